// File: rtl/fir_regs_pkg.sv
// Shared definitions for the FIR register responder: address map, widths,
// and the write-qualifier state encoding.
package fir_regs_pkg;

    localparam int REG_W      = 16;
    localparam int ADDR_W     = 6;
    localparam int COEF_N     = 16;
    localparam int COEF_IDX_W = 4;
    localparam int ERR_W      = 8;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'h01;
    localparam logic [ADDR_W-1:0] ADDR_LEN    = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_ERRCNT = 6'h03;

    typedef enum logic [1:0] {
        WQ_IDLE     = 2'd0,
        WQ_CAPTURE  = 2'd1,
        WQ_WAIT_LOW = 2'd2
    } wq_state_e;

    // Coefficients occupy 0x10-0x1F.
    function automatic logic is_coef_addr(input logic [ADDR_W-1:0] a);
        return a[5:4] == 2'b01;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// 16x16 coefficient storage: one write port, one readback port for the
// bridge and one read port for the FIR datapath.
module fir_coef_bank
    import fir_regs_pkg::*;
(
    input  logic                  clk_b,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [COEF_IDX_W-1:0] waddr,
    input  logic [REG_W-1:0]      wdata,
    input  logic [COEF_IDX_W-1:0] raddr_a,
    output logic [REG_W-1:0]      rdata_a,
    input  logic [COEF_IDX_W-1:0] raddr_b,
    output logic [REG_W-1:0]      rdata_b
);

    logic [REG_W-1:0] mem [COEF_N];

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            for (int i = 0; i < COEF_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fir_reg_responder.sv
// Register responder for the FIR block, fed by an unhandshaked CDC bridge.
// A write is accepted only once address/data have been seen stable for two edges.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   WQ_IDLE     | waiting for a 0->1 edge on CDC_wr
//   WQ_CAPTURE  | A/D latched; write fires when the next sample matches
//   WQ_WAIT_LOW | write done (or abandoned); wait for CDC_wr to drop
module fir_reg_responder
    import fir_regs_pkg::*;
(
    input  logic                  clk_b,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     CDC_A,
    input  logic [REG_W-1:0]      CDC_data,
    input  logic                  CDC_wr,
    output logic [REG_W-1:0]      data_back,
    output logic                  fir_start,
    input  logic                  fir_busy,
    input  logic                  fir_done,
    output logic [REG_W-1:0]      sample_len,
    input  logic [COEF_IDX_W-1:0] coef_idx,
    output logic [REG_W-1:0]      coef_data
);

    wq_state_e         state;
    logic              prev_wr;
    logic              armed;
    logic [ADDR_W-1:0] lat_a;
    logic [REG_W-1:0]  lat_d;

    logic              wr_fire, wr_ctrl, wr_status, wr_len, wr_coef, wr_bad;
    logic              err_inc, err_clr, done_clr;
    logic [REG_W-1:0]  len_q, rd_val, coef_rd;
    logic [ERR_W-1:0]  errcnt;
    logic              done;

    assign wr_fire   = (state == WQ_CAPTURE) && CDC_wr &&
                       (CDC_A == lat_a) && (CDC_data == lat_d);
    assign wr_ctrl   = wr_fire && (lat_a == ADDR_CTRL);
    assign wr_status = wr_fire && (lat_a == ADDR_STATUS);
    assign wr_len    = wr_fire && (lat_a == ADDR_LEN);
    assign wr_coef   = wr_fire && is_coef_addr(lat_a);
    assign wr_bad    = wr_fire && !wr_ctrl && !wr_status && !wr_len && !wr_coef;

    assign err_inc  = wr_bad || (wr_ctrl && lat_d[0] && fir_busy);
    assign err_clr  = wr_ctrl && lat_d[1];
    assign done_clr = (wr_ctrl || wr_status) && lat_d[1];

    // armed keeps a CDC_wr held high across reset release from looking like a rising edge.
    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            state   <= WQ_IDLE;
            prev_wr <= 1'b0;
            armed   <= 1'b0;
            lat_a   <= '0;
            lat_d   <= '0;
        end else begin
            armed   <= 1'b1;
            prev_wr <= CDC_wr;
            case (state)
                WQ_IDLE: begin
                    if (CDC_wr && !prev_wr && armed) begin
                        lat_a <= CDC_A;
                        lat_d <= CDC_data;
                        state <= WQ_CAPTURE;
                    end
                end
                WQ_CAPTURE: begin
                    if (!CDC_wr) begin
                        state <= WQ_IDLE;
                    end else if (wr_fire) begin
                        state <= WQ_WAIT_LOW;
                    end else begin
                        lat_a <= CDC_A;
                        lat_d <= CDC_data;
                    end
                end
                WQ_WAIT_LOW: begin
                    if (!CDC_wr) begin
                        state <= WQ_IDLE;
                    end
                end
                default: state <= WQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            len_q     <= '0;
            errcnt    <= '0;
            done      <= 1'b0;
            fir_start <= 1'b0;
            data_back <= '0;
        end else begin
            fir_start <= wr_ctrl && lat_d[0] && !fir_busy;
            data_back <= rd_val;
            if (wr_len) begin
                len_q <= lat_d;
            end
            if (fir_done) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end
            if (err_clr) begin
                errcnt <= '0;
            end else if (err_inc && (errcnt != {ERR_W{1'b1}})) begin
                errcnt <= errcnt + 8'd1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_coef_addr(CDC_A)) begin
            rd_val = coef_rd;
        end else begin
            case (CDC_A)
                ADDR_STATUS: rd_val = {{(REG_W-2){1'b0}}, done, fir_busy};
                ADDR_LEN:    rd_val = len_q;
                ADDR_ERRCNT: rd_val = {{(REG_W-ERR_W){1'b0}}, errcnt};
                default:     rd_val = '0;
            endcase
        end
    end

    fir_coef_bank u_coef_bank (
        .clk_b   (clk_b),
        .rst_n   (rst_n),
        .we      (wr_coef),
        .waddr   (lat_a[COEF_IDX_W-1:0]),
        .wdata   (lat_d),
        .raddr_a (CDC_A[COEF_IDX_W-1:0]),
        .rdata_a (coef_rd),
        .raddr_b (coef_idx),
        .rdata_b (coef_data)
    );

    assign sample_len = len_q;

endmodule

// File: tb/tb_fir_reg_responder.sv
// Self-checking bench for fir_reg_responder: readback expectations are queued
// from a behavioural register model and compared when data_back returns.
module tb_fir_reg_responder;

    logic        clk_b = 1'b0;
    logic        rst_n;
    logic [5:0]  CDC_A;
    logic [15:0] CDC_data;
    logic        CDC_wr;
    logic [15:0] data_back;
    logic        fir_start;
    logic        fir_busy;
    logic        fir_done;
    logic [15:0] sample_len;
    logic [3:0]  coef_idx;
    logic [15:0] coef_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_len;
    logic [15:0] m_coef [16];
    logic [7:0]  m_err;
    logic        m_done;
    logic [15:0] exp_q [$];

    int start_cnt;
    int start_pos;

    fir_reg_responder dut (
        .clk_b      (clk_b),
        .rst_n      (rst_n),
        .CDC_A      (CDC_A),
        .CDC_data   (CDC_data),
        .CDC_wr     (CDC_wr),
        .data_back  (data_back),
        .fir_start  (fir_start),
        .fir_busy   (fir_busy),
        .fir_done   (fir_done),
        .sample_len (sample_len),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data)
    );

    always #5 clk_b = ~clk_b;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_b);
        #1;
        if (fir_start) begin
            start_cnt++;
        end
    endtask

    task automatic model_reset();
        m_len  = '0;
        m_err  = '0;
        m_done = 1'b0;
        for (int i = 0; i < 16; i++) m_coef[i] = '0;
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [15:0] d, input logic busy);
        if (a == 6'h00) begin
            if (d[1]) begin
                m_err  = '0;
                m_done = 1'b0;
            end else if (d[0] && busy) begin
                m_err = sat_inc(m_err);
            end
        end else if (a == 6'h01) begin
            if (d[1]) m_done = 1'b0;
        end else if (a == 6'h02) begin
            m_len = d;
        end else if (a[5:4] == 2'b01) begin
            m_coef[a[3:0]] = d;
        end else begin
            m_err = sat_inc(m_err);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [5:0] a);
        if (a[5:4] == 2'b01) return m_coef[a[3:0]];
        case (a)
            6'h01:   return {14'b0, m_done, fir_busy};
            6'h02:   return m_len;
            6'h03:   return {8'b0, m_err};
            default: return 16'h0000;
        endcase
    endfunction

    // Clean write: CDC_wr high for 4 cycles, then low long enough to re-arm.
    task automatic wr_reg(input logic [5:0] a, input logic [15:0] d, input logic done_at_write);
        logic busy_at_write;
        start_cnt = 0;
        start_pos = 0;
        CDC_A    = a;
        CDC_data = d;
        CDC_wr   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                busy_at_write = fir_busy;
                if (done_at_write) fir_done = 1'b1;
            end
            tick();
            if (fir_start && start_pos == 0) start_pos = k;
            fir_done = 1'b0;
            if (k == 4) CDC_wr = 1'b0;
        end
        model_write(a, d, busy_at_write);
        if (done_at_write) m_done = 1'b1;
    endtask

    task automatic rd_reg(input string tag, input logic [5:0] a);
        logic [15:0] e;
        CDC_A = a;
        exp_q.push_back(model_read(a));
        tick();
        e = exp_q.pop_front();
        check_val(tag, data_back, e);
    endtask

    initial begin
        rst_n    = 1'b0;
        CDC_A    = '0;
        CDC_data = '0;
        CDC_wr   = 1'b0;
        fir_busy = 1'b0;
        fir_done = 1'b0;
        coef_idx = 4'd0;
        model_reset();
        repeat (3) tick();
        check_val("rst_data_back", data_back, 16'h0000);
        check_val("rst_fir_start", {15'b0, fir_start}, 16'h0000);
        check_val("rst_sample_len", sample_len, 16'h0000);
        check_val("rst_coef_data", coef_data, 16'h0000);
        rst_n = 1'b1;
        repeat (2) tick();

        // LEN write latency: value appears at the second edge after the rise, once only.
        CDC_A = 6'h02; CDC_data = 16'h1234; CDC_wr = 1'b1;
        tick();
        check_val("len_edge1", sample_len, 16'h0000);
        tick();
        check_val("len_edge2", sample_len, 16'h1234);
        CDC_data = 16'hFFFF;
        repeat (2) tick();
        check_val("len_held_high", sample_len, 16'h1234);
        CDC_wr = 1'b0; CDC_data = 16'h1234;
        repeat (2) tick();
        m_len = 16'h1234;
        rd_reg("rd_len", 6'h02);

        // Data settles one cycle late: only the settled value may land.
        coef_idx = 4'd5;
        CDC_A = 6'h15; CDC_data = 16'hAAAA; CDC_wr = 1'b1;
        tick();
        CDC_data = 16'h5555;
        tick();
        check_val("coef_no_early", coef_data, 16'h0000);
        tick();
        check_val("coef_settled", coef_data, 16'h5555);
        tick();
        CDC_wr = 1'b0;
        repeat (2) tick();
        m_coef[5] = 16'h5555;
        rd_reg("rd_coef5", 6'h15);
        wr_reg(6'h1F, 16'hC0DE, 1'b0);
        coef_idx = 4'd15;
        #1;
        check_val("coef_idx15", coef_data, 16'hC0DE);
        rd_reg("rd_coef15", 6'h1F);

        // FIR start pulse, then rejected start while busy.
        wr_reg(6'h00, 16'h0001, 1'b0);
        check_val("start_count", 16'(start_cnt), 16'd1);
        check_val("start_pos", 16'(start_pos), 16'd2);
        fir_busy = 1'b1;
        wr_reg(6'h00, 16'h0001, 1'b0);
        check_val("busy_no_start", 16'(start_cnt), 16'd0);
        rd_reg("errcnt_busy", 6'h03);
        rd_reg("status_busy", 6'h01);
        fir_busy = 1'b0;

        // done set and STATUS clear in the same cycle: set wins.
        wr_reg(6'h01, 16'h0002, 1'b1);
        rd_reg("status_set_wins", 6'h01);
        wr_reg(6'h01, 16'h0002, 1'b0);
        rd_reg("status_cleared", 6'h01);

        // ERRCNT saturation and clear.
        wr_reg(6'h03, 16'hFFFF, 1'b0);
        rd_reg("errcnt_ro_write", 6'h03);
        for (int n = 0; n < 300; n++) wr_reg(6'h3F, 16'h0BAD, 1'b0);
        rd_reg("errcnt_sat", 6'h03);
        rd_reg("rd_unmapped", 6'h3F);
        rd_reg("rd_ctrl", 6'h00);
        check_val("len_untouched", sample_len, m_len);
        wr_reg(6'h00, 16'h0002, 1'b0);
        rd_reg("errcnt_clear", 6'h03);
        wr_reg(6'h3F, 16'h0000, 1'b0);
        fir_busy = 1'b1;
        wr_reg(6'h00, 16'h0003, 1'b0);
        rd_reg("clear_wins", 6'h03);
        fir_busy = 1'b0;

        // COEF/LEN writes while busy still land.
        fir_busy = 1'b1;
        wr_reg(6'h02, 16'h00C8, 1'b0);
        check_val("len_while_busy", sample_len, 16'h00C8);
        fir_busy = 1'b0;

        // Reset mid-CAPTURE with CDC_wr held through release.
        CDC_A = 6'h02; CDC_data = 16'hBEEF; CDC_wr = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick();
        check_val("rst_abandon_len", sample_len, 16'h0000);
        coef_idx = 4'd5;
        #1;
        check_val("rst_coef_clear", coef_data, 16'h0000);
        CDC_wr = 1'b0;
        repeat (2) tick();
        CDC_A = 6'h02; CDC_data = 16'h0042; CDC_wr = 1'b1;
        tick();
        tick();
        check_val("post_rst_write", sample_len, 16'h0042);
        CDC_wr = 1'b0;
        repeat (2) tick();
        m_len = 16'h0042;
        rd_reg("post_rst_rd_len", 6'h02);
        rd_reg("post_rst_errcnt", 6'h03);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_reg_responder.md
FIR_REG_RESPONDER -- requirements
Module: fir_reg_responder

Interface
REQ-001 clk_b  input  1  sole clock (FIR/domain-B clock); all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 CDC_A  input  6  register address from the CDC bridge; not handshaked, may glitch for one cycle.
REQ-004 CDC_data  input  16  write data from the CDC bridge; not handshaked.
REQ-005 CDC_wr  input  1  write level from the CDC bridge; a write request is one 0->1 transition.
REQ-006 data_back  output  16  registered readback of register at CDC_A, returned to the bridge.
REQ-007 fir_start  output  1  one-cycle start pulse to the FIR datapath.
REQ-008 fir_busy  input  1  FIR datapath busy level.
REQ-009 fir_done  input  1  FIR completion pulse, one cycle.
REQ-010 sample_len  output  16  LEN register value.
REQ-011 coef_idx  input  4  coefficient read index from the FIR datapath.
REQ-012 coef_data  output  16  coefficient at coef_idx, combinational from the bank.

Function
REQ-013 Address map: 0x00 CTRL (write-only, reads 0), 0x01 STATUS, 0x02 LEN (RW), 0x03 ERRCNT (RO, bits 7:0), 0x10-0x1F COEF[0..15] (RW); all other addresses read 0.
REQ-014 Write qualifier FSM states: IDLE, CAPTURE, WAIT_LOW.
REQ-015 IDLE: on CDC_wr=1 with registered previous CDC_wr=0 -> latch CDC_A/CDC_data, go CAPTURE.
REQ-016 CAPTURE: if CDC_wr=0 -> IDLE, no write; else if CDC_A and CDC_data equal the latched values -> perform write at this edge, go WAIT_LOW; else relatch, stay CAPTURE.
REQ-017 WAIT_LOW: no write; CDC_wr=0 -> IDLE; a held-high CDC_wr never produces a second write.
REQ-018 Write latency: target register holds new value 2 clk_b edges after the edge that first samples CDC_wr=1, given stable A/D.
REQ-019 CTRL write bit0=1: if fir_busy=0, fir_start=1 for exactly the next cycle; if fir_busy=1, no pulse and ERRCNT increments.
REQ-020 CTRL write bit1=1: clears STATUS.done and ERRCNT; bits 15:2 ignored.
REQ-021 STATUS read: bit0 = fir_busy (live), bit1 = done sticky, others 0.
REQ-022 done sticky sets on fir_done; STATUS write with bit1=1 clears it; simultaneous set and clear -> set wins.
REQ-023 Writes to 0x03 or unmapped addresses change nothing except ERRCNT increment.
REQ-024 ERRCNT saturates at 255; simultaneous increment and clear -> clear wins.
REQ-025 data_back updated every cycle from current CDC_A, 1-cycle latency, independent of FSM state.
REQ-026 Writes to COEF/LEN take effect regardless of fir_busy.

Reset
REQ-027 rst_n=0 at a clock edge: FSM IDLE, previous-wr register 0, all registers, coefficients, done, ERRCNT, data_back, fir_start = 0.
REQ-028 Reset asserted mid-CAPTURE abandons the pending write; CDC_wr still high after reset release is not a rising edge (previous-wr register reloads from CDC_wr after first post-reset cycle, no write).

Structure
REQ-029 Shared package fir_regs_pkg holds address constants, register width, coefficient count (16), FSM state enum.
REQ-030 Sub-module fir_coef_bank: 16x16 register array, one write port, two read ports (readback, coef_idx).

Verification
REQ-031 Write 0x02=0x1234 with stable A/D, CDC_wr high 4 cycles -> sample_len=0x1234 two edges after rise, single write.
REQ-032 CDC_data changes 0xAAAA->0x5555 on cycle after rise, then stable -> COEF value 0x5555, never 0xAAAA.
REQ-033 Write CTRL=0x0001, fir_busy=0 -> one-cycle fir_start; repeat with fir_busy=1 -> no pulse, ERRCNT=1.
REQ-034 fir_done pulse coincident with STATUS write 0x0002 -> STATUS reads 0x0002 (busy 0).
REQ-035 300 writes to 0x3F -> ERRCNT=255; CTRL write 0x0002 -> ERRCNT=0.
REQ-036 Reset during CAPTURE with CDC_wr held high through release -> no register change, FSM IDLE.
